// File: rtl/bus_decode_mux.sv
// CPU bus glue: decodes the 65C02 address into one-hot slot selects,
// inserts per-slot wait states, merges slot ready and registers read data.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   cpu_ab/cpu_we  CPU address and write enable
//   cpu_di         read data to CPU (one cycle after completion)
//   cpu_rdy        CPU ready; low stalls the CPU
//   sel            one-hot slot select (combinational)
//   wr_stb         write strobe on the completion cycle of a write
//   slot_do        packed slot read data, slot i at [i*DW +: DW]
//   slot_rdy       per-slot ready
//   err_clr        clears err_flags and err_addr
//   err_flags      sticky {timeout, unmapped}
//   err_addr       address of the first error since the last clear
module bus_decode_mux #(
    parameter int NSLOT = 8,
    parameter int AW = 16,
    parameter int DW = 8,
    parameter logic [NSLOT*AW-1:0] SLOT_BASE = {NSLOT{16'h0000}},
    parameter logic [NSLOT*AW-1:0] SLOT_MASK = {NSLOT{16'hffff}},
    parameter logic [NSLOT*4-1:0] SLOT_WAIT = {NSLOT{4'h0}},
    parameter int TIMEOUT = 255,
    parameter logic [DW-1:0] UNMAP_DATA = 8'hff,
    parameter logic [DW-1:0] ERR_DATA = 8'hff
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AW-1:0]       cpu_ab,
    input  logic                cpu_we,
    output logic [DW-1:0]       cpu_di,
    output logic                cpu_rdy,
    output logic [NSLOT-1:0]    sel,
    output logic [NSLOT-1:0]    wr_stb,
    input  logic [NSLOT*DW-1:0] slot_do,
    input  logic [NSLOT-1:0]    slot_rdy,
    input  logic                err_clr,
    output logic [1:0]          err_flags,
    output logic [AW-1:0]       err_addr
);

    localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [NSLOT-1:0] hit;
    logic [IW-1:0]    win_idx;
    logic             hit_any;
    logic [3:0]       win_wait;
    logic             win_rdy;

    logic             rdy_q;
    logic [3:0]       wcnt;
    logic [3:0]       ecnt;
    logic [7:0]       tcnt;
    logic             stall;
    logic             force_done;

    logic [NSLOT-1:0] mux_sel;
    logic             err_q;
    logic [DW-1:0]    rd_mux;
    logic [1:0]       err_set;

    // Address windows; the lowest-index hit wins on overlap.
    always_comb begin
        hit = '0;
        win_idx = '0;
        hit_any = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            hit[i] = (cpu_ab & SLOT_MASK[i*AW +: AW]) == SLOT_BASE[i*AW +: AW];
        end
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_idx = IW'(i);
                hit_any = 1'b1;
            end
        end
    end

    assign sel = hit_any ? (NSLOT'(1) << win_idx) : '0;

    // Unmapped accesses complete immediately with no wait states.
    assign win_wait = hit_any ? SLOT_WAIT[win_idx*4 +: 4] : 4'd0;
    assign win_rdy  = hit_any ? slot_rdy[win_idx] : 1'b1;

    // The first cycle of an access loads the slot's wait count;
    // later cycles continue from the registered countdown.
    assign ecnt       = rdy_q ? win_wait : wcnt;
    assign stall      = !((ecnt == 4'd0) && win_rdy);
    assign force_done = stall && (tcnt == 8'(TIMEOUT - 1));
    assign cpu_rdy    = force_done || !stall;

    assign wr_stb = sel & {NSLOT{cpu_we & cpu_rdy}};

    assign err_set = {force_done, cpu_rdy & ~hit_any};

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q <= 1'b1;
            wcnt  <= 4'd0;
            tcnt  <= 8'd0;
        end else begin
            rdy_q <= cpu_rdy;
            if (force_done || ecnt == 4'd0) begin
                wcnt <= 4'd0;
            end else begin
                wcnt <= ecnt - 4'd1;
            end
            if (cpu_rdy) begin
                tcnt <= 8'd0;
            end else begin
                tcnt <= tcnt + 8'd1;
            end
        end
    end

    // Read path is captured on completion, giving one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            mux_sel <= '0;
            err_q   <= 1'b0;
        end else if (cpu_rdy) begin
            mux_sel <= sel;
            err_q   <= force_done;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (mux_sel[i]) begin
                rd_mux = rd_mux | slot_do[i*DW +: DW];
            end
        end
    end

    assign cpu_di = err_q ? ERR_DATA :
                    (mux_sel == '0) ? UNMAP_DATA : rd_mux;

    // A new error beats a simultaneous clear; the address is only
    // captured for the first error since the flags were last empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flags <= 2'b00;
            err_addr  <= '0;
        end else if (err_set != 2'b00) begin
            err_flags <= (err_clr ? 2'b00 : err_flags) | err_set;
            if (err_clr || err_flags == 2'b00) begin
                err_addr <= cpu_ab;
            end
        end else if (err_clr) begin
            err_flags <= 2'b00;
            err_addr  <= '0;
        end
    end

endmodule

// File: tb/tb_bus_decode_mux.sv
// Self-checking bench for bus_decode_mux: decode, wait states, stall,
// timeout, unmapped errors and reset during a stall.
module tb_bus_decode_mux;

    localparam int NSLOT = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     cpu_ab;
    logic              cpu_we;
    logic [DW-1:0]     cpu_di;
    logic              cpu_rdy;
    logic [NSLOT-1:0]  sel;
    logic [NSLOT-1:0]  wr_stb;
    logic [NSLOT*DW-1:0] slot_do;
    logic [NSLOT-1:0]  slot_rdy;
    logic              err_clr;
    logic [1:0]        err_flags;
    logic [AW-1:0]     err_addr;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e;

    always #5 clk = ~clk;

    // slot0 0000-7fff w0, slot1 8000-8fff w0, slot2 9000-9fff w3,
    // slot3 8000-bfff w1 (overlaps slot1). c000-ffff unmapped.
    bus_decode_mux #(
        .NSLOT(NSLOT), .AW(AW), .DW(DW),
        .SLOT_BASE({16'h8000, 16'h9000, 16'h8000, 16'h0000}),
        .SLOT_MASK({16'hc000, 16'hf000, 16'hf000, 16'h8000}),
        .SLOT_WAIT({4'd1, 4'd3, 4'd0, 4'd0}),
        .TIMEOUT(16),
        .UNMAP_DATA(8'hff),
        .ERR_DATA(8'hee)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_di(cpu_di),
        .cpu_rdy(cpu_rdy), .sel(sel), .wr_stb(wr_stb),
        .slot_do(slot_do), .slot_rdy(slot_rdy),
        .err_clr(err_clr), .err_flags(err_flags), .err_addr(err_addr)
    );

    // Drive one cycle of inputs just after the edge, then wait to mid-cycle.
    task automatic step(input logic [AW-1:0] a, input logic we,
                        input logic r1, input logic clr, input logic rst);
        @(posedge clk);
        #1;
        cpu_ab = a;
        cpu_we = we;
        slot_rdy = {2'b11, r1, 1'b1};
        err_clr = clr;
        reset = rst;
        #3;
    endtask

    task automatic test_reset;
        step(16'h1234, 0, 1, 0, 1);
        step(16'h1234, 0, 1, 0, 1);
        step(16'h1234, 0, 1, 0, 0);
        n_vec++;
        if (cpu_di !== 8'hff) begin
            n_err++; $display("FAIL reset_di got %h exp ff", cpu_di);
        end
        n_vec++;
        if (err_flags !== 2'b00 || err_addr !== 16'h0000) begin
            n_err++; $display("FAIL reset_err got %b/%h exp 00/0000", err_flags, err_addr);
        end
        n_vec++;
        if (cpu_rdy !== 1'b1) begin
            n_err++; $display("FAIL reset_rdy got %b exp 1", cpu_rdy);
        end
    endtask

    task automatic test_wait0;
        step(16'h1234, 0, 1, 0, 0);
        n_vec++;
        if (cpu_rdy !== 1'b1 || sel !== 4'b0001) begin
            n_err++; $display("FAIL wait0_rdy_sel got %b/%b exp 1/0001", cpu_rdy, sel);
        end
        exp_q.push_back(8'ha0);
        step(16'h0000, 0, 1, 0, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e) begin
            n_err++; $display("FAIL wait0_di got %h exp %h", cpu_di, e);
        end
    endtask

    task automatic test_back_to_back;
        step(16'h4321, 0, 1, 0, 0);
        exp_q.push_back(8'ha0);
        step(16'h8456, 0, 1, 0, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e || cpu_rdy !== 1'b1) begin
            n_err++; $display("FAIL b2b_0 got %h/%b exp %h/1", cpu_di, cpu_rdy, e);
        end
        exp_q.push_back(8'ha1);
        step(16'h0010, 0, 1, 0, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e) begin
            n_err++; $display("FAIL b2b_1 got %h exp %h", cpu_di, e);
        end
    endtask

    task automatic test_wait3;
        for (int c = 0; c < 4; c++) begin
            step(16'h9000, 0, 1, 0, 0);
            n_vec++;
            if (cpu_rdy !== (c == 3) || wr_stb !== 4'b0000) begin
                n_err++; $display("FAIL wait3_rd c%0d got %b/%b exp %b/0000", c, cpu_rdy, wr_stb, c == 3);
            end
        end
        exp_q.push_back(8'ha2);
        step(16'h0000, 0, 1, 0, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e) begin
            n_err++; $display("FAIL wait3_di got %h exp %h", cpu_di, e);
        end
        for (int c = 0; c < 4; c++) begin
            step(16'h9001, 1, 1, 0, 0);
            n_vec++;
            if (wr_stb !== ((c == 3) ? 4'b0100 : 4'b0000)) begin
                n_err++; $display("FAIL wait3_wr c%0d got %b", c, wr_stb);
            end
        end
        step(16'h0000, 0, 1, 0, 0);
    endtask

    task automatic test_stall;
        for (int c = 0; c < 6; c++) begin
            step(16'h8000, 0, c == 5, 0, 0);
            n_vec++;
            if (cpu_rdy !== (c == 5) || sel !== 4'b0010) begin
                n_err++; $display("FAIL stall c%0d got %b/%b exp %b/0010", c, cpu_rdy, sel, c == 5);
            end
        end
        exp_q.push_back(8'ha1);
        step(16'h0000, 0, 1, 0, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e || err_flags !== 2'b00) begin
            n_err++; $display("FAIL stall_done got %h/%b exp %h/00", cpu_di, err_flags, e);
        end
    endtask

    task automatic test_timeout;
        for (int c = 0; c < 16; c++) begin
            step(16'h8123, 0, 0, 0, 0);
            n_vec++;
            if (cpu_rdy !== (c == 15)) begin
                n_err++; $display("FAIL timeout c%0d got %b exp %b", c, cpu_rdy, c == 15);
            end
        end
        exp_q.push_back(8'hee);
        step(16'h0000, 0, 1, 0, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e) begin
            n_err++; $display("FAIL timeout_di got %h exp %h", cpu_di, e);
        end
        n_vec++;
        if (err_flags !== 2'b10 || err_addr !== 16'h8123) begin
            n_err++; $display("FAIL timeout_err got %b/%h exp 10/8123", err_flags, err_addr);
        end
        exp_q.push_back(8'ha0);
        step(16'h0000, 0, 1, 1, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e) begin
            n_err++; $display("FAIL timeout_recover got %h exp %h", cpu_di, e);
        end
        step(16'h0000, 0, 1, 0, 0);
        n_vec++;
        if (err_flags !== 2'b00 || err_addr !== 16'h0000) begin
            n_err++; $display("FAIL err_clr got %b/%h exp 00/0000", err_flags, err_addr);
        end
    endtask

    task automatic test_unmapped;
        step(16'hc000, 0, 1, 0, 0);
        n_vec++;
        if (cpu_rdy !== 1'b1 || sel !== 4'b0000) begin
            n_err++; $display("FAIL unmap_rdy_sel got %b/%b exp 1/0000", cpu_rdy, sel);
        end
        exp_q.push_back(8'hff);
        step(16'hd000, 0, 1, 0, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e || err_flags !== 2'b01 || err_addr !== 16'hc000) begin
            n_err++; $display("FAIL unmap_first got %h/%b/%h exp %h/01/c000", cpu_di, err_flags, err_addr, e);
        end
        step(16'h0000, 0, 1, 0, 0);
        n_vec++;
        if (err_flags !== 2'b01 || err_addr !== 16'hc000) begin
            n_err++; $display("FAIL unmap_hold got %b/%h exp 01/c000", err_flags, err_addr);
        end
        step(16'he000, 0, 1, 1, 0);
        step(16'h0000, 0, 1, 0, 0);
        n_vec++;
        if (err_flags !== 2'b01 || err_addr !== 16'he000) begin
            n_err++; $display("FAIL unmap_clr_set got %b/%h exp 01/e000", err_flags, err_addr);
        end
        step(16'h0000, 0, 1, 1, 0);
        step(16'hf000, 1, 1, 0, 0);
        n_vec++;
        if (wr_stb !== 4'b0000 || err_flags !== 2'b00) begin
            n_err++; $display("FAIL unmap_wr got %b/%b exp 0000/00", wr_stb, err_flags);
        end
        step(16'h0000, 0, 1, 0, 0);
        n_vec++;
        if (err_flags !== 2'b01 || err_addr !== 16'hf000) begin
            n_err++; $display("FAIL unmap_wr_err got %b/%h exp 01/f000", err_flags, err_addr);
        end
    endtask

    task automatic test_reset_midstall;
        step(16'h9000, 0, 1, 0, 0);
        step(16'h9000, 0, 1, 0, 1);
        for (int c = 0; c < 4; c++) begin
            step(16'h9000, 0, 1, 0, 0);
            if (c == 0) begin
                n_vec++;
                if (cpu_di !== 8'hff || err_flags !== 2'b00 || err_addr !== 16'h0000) begin
                    n_err++; $display("FAIL rst_mid got %h/%b/%h exp ff/00/0000", cpu_di, err_flags, err_addr);
                end
            end
            n_vec++;
            if (cpu_rdy !== (c == 3)) begin
                n_err++; $display("FAIL rst_mid_wait c%0d got %b exp %b", c, cpu_rdy, c == 3);
            end
        end
        exp_q.push_back(8'ha2);
        step(16'h0000, 0, 1, 0, 0);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        n_vec++;
        if (cpu_di !== e) begin
            n_err++; $display("FAIL rst_mid_di got %h exp %h", cpu_di, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_ab = '0;
        cpu_we = 1'b0;
        err_clr = 1'b0;
        slot_rdy = '1;
        slot_do = {8'ha3, 8'ha2, 8'ha1, 8'ha0};
        test_reset();
        test_wait0();
        test_back_to_back();
        test_wait3();
        test_stall();
        test_timeout();
        test_unmapped();
        test_reset_midstall();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
